// File: rtl/fft_pkg.sv
// Shared types and the rounding/saturation helpers for the round scheduler.
// Holds default sample widths, round mode and output-stage state encodings.
// Helpers work on a 64-bit sign-extended sample so any IN_W < 64 fits.
package fft_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 16;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Arithmetic shift by `shift`, with a half-LSB bias added first in
  // round mode. The 64-bit sum cannot overflow for any IN_W < 64.
  function automatic logic signed [63:0] round_raw(
    input logic signed [63:0] x,
    input int unsigned        shift,
    input round_mode_e        mode
  );
    logic signed [63:0] bias;
    bias = (mode == RND_HALF_UP) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
    return (x + bias) >>> shift;
  endfunction

  // Only the rounding bias can push a value past the positive output limit;
  // truncation of an in-range sample always fits, and negatives move up.
  function automatic logic round_sat(
    input logic signed [63:0] x,
    input int unsigned        shift,
    input int unsigned        out_w,
    input round_mode_e        mode
  );
    logic signed [63:0] max_pos;
    max_pos = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    return (mode == RND_HALF_UP) && (round_raw(x, shift, mode) > max_pos);
  endfunction

  // Final result: the shifted value, or the largest positive code on overflow.
  function automatic logic signed [63:0] round_sample(
    input logic signed [63:0] x,
    input int unsigned        shift,
    input int unsigned        out_w,
    input round_mode_e        mode
  );
    if (round_sat(x, shift, out_w, mode)) begin
      return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    end
    return round_raw(x, shift, mode);
  endfunction

endpackage

// File: rtl/round_scheduler_if.sv
// Requester and output handshake bundle for the round scheduler.
// Ports: req_valid/req_data/req_ready per requester; out_valid/out_data/
// out_id/out_ready for the single rounded output stream.
interface round_scheduler_if import fft_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0][IN_W-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic                       out_valid;
  logic [OUT_W-1:0]           out_data;
  logic [ID_W-1:0]            out_id;
  logic                       out_ready;

  // Traffic source/sink side (requesters plus downstream consumer).
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant picker, purely combinational.
// Ports: req_i request vector, ptr_i last granted index, en_i grant enable;
// gnt_o one-hot (or zero) grant, gnt_idx_o index of the granted requester.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o
);

  // One extra bit so ptr + offset (at most 2*N_REQ-1) never wraps.
  localparam logic [ID_W:0] N_W = (ID_W + 1)'(N_REQ);

  logic          found;
  logic [ID_W:0] k;

  // Walk ptr+1 .. ptr+N_REQ (mod N_REQ); the first active request wins,
  // so the previous winner is visited last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    k         = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = {1'b0, ptr_i} + (ID_W + 1)'(i);
      if (k >= N_W) begin
        k = k - N_W;
      end
      if (en_i && !found && req_i[k[ID_W-1:0]]) begin
        found               = 1'b1;
        gnt_o[k[ID_W-1:0]]  = 1'b1;
        gnt_idx_o           = k[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// Shares one rounding datapath among N_REQ requesters with round-robin
// arbitration and a single-entry output register (1-cycle latency).
// Ports: clk/rst; bus (slave modport) handshakes; round_mode selects
// truncate vs round-half-up; sat_count/sat_clr expose saturation events.
module round_scheduler import fft_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  round_scheduler_if.slave    bus,
  input  logic                round_mode,
  input  logic                sat_clr,
  output logic [15:0]         sat_count
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int SHIFT = IN_W - OUT_W;
  // Pointer starts at the last index so requester 0 is searched first.
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

  out_state_e         state_q, state_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [15:0]        sat_q, sat_d;

  logic               grant_en;
  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               in_xfer;
  logic [IN_W-1:0]    sel_data;
  logic signed [63:0] sel_ext;
  round_mode_e        mode;

  // Accept a new sample when the register is free or is being drained in
  // the same cycle; held off entirely while reset is asserted.
  assign grant_en = !rst && ((state_q == ST_EMPTY) || bus.out_ready);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (last_q),
    .en_i      (grant_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Grant is only ever issued to a valid requester, so any grant is a transfer.
  assign bus.req_ready = gnt;
  assign in_xfer       = |gnt;
  assign sel_data      = bus.req_data[gnt_idx];
  assign sel_ext       = {{(64 - IN_W){sel_data[IN_W-1]}}, sel_data};
  assign mode          = round_mode_e'(round_mode);

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign sat_count     = sat_q;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    last_d     = last_q;
    sat_d      = sat_q;

    case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_FULL;
      ST_FULL: begin
        if (in_xfer) begin
          state_d = ST_FULL;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (in_xfer) begin
      out_data_d = OUT_W'(round_sample(sel_ext, SHIFT, OUT_W, mode));
      out_id_d   = gnt_idx;
      last_d     = gnt_idx;
    end

    // Clear wins over a simultaneous saturation; the counter sticks at max.
    if (sat_clr) begin
      sat_d = '0;
    end else if (in_xfer && round_sat(sel_ext, SHIFT, OUT_W, mode) &&
                 (sat_q != 16'hFFFF)) begin
      sat_d = sat_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      last_q     <= LAST_RST;
      sat_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      last_q     <= last_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: tb/tb_round_scheduler.sv
// Directed bench for round_scheduler: arbitration order, rounding modes,
// saturation counting/clear, output hold under backpressure, async reset.
module tb_round_scheduler;
  import fft_pkg::*;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        round_mode;
  logic        sat_clr;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;

  round_scheduler_if #(.N_REQ(N), .IN_W(32), .OUT_W(16)) bus ();

  round_scheduler #(
    .N_REQ (N),
    .IN_W  (32),
    .OUT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .round_mode (round_mode),
    .sat_clr    (sat_clr),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample from a single requester; checks grant, then the registered result.
  task automatic send(input int idx, input logic [31:0] data, input logic mode,
                      input logic [15:0] exp, input string tag);
    bus.req_data[idx] = data;
    bus.req_valid     = 4'(1 << idx);
    round_mode        = mode;
    #1;
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(1 << idx));
    tick();
    bus.req_valid = '0;
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(bus.out_data), 32'(exp));
    chk({tag, "_id"},  32'(bus.out_id), 32'(idx));
  endtask

  initial begin
    rst           = 1'b1;
    sat_clr       = 1'b0;
    round_mode    = 1'b0;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'hF;
    for (int i = 0; i < N; i++) bus.req_data[i] = 32'(i) << 16;

    // Reset values, and no grants while reset is held.
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_id",    32'(bus.out_id),    32'd0);
    chk("rst_sat_count", 32'(sat_count),     32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // Round-robin with all requesters active and no backpressure.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr_first_rdy", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_vld", 32'(bus.out_valid), 32'd1);
      chk("rr_id",  32'(bus.out_id),    32'(k % 4));
      chk("rr_dat", 32'(bus.out_data),  32'(k % 4));
      chk("rr_rdy", 32'(bus.req_ready), 32'(1 << ((k + 1) % 4)));
    end
    bus.req_valid = '0;
    tick();
    chk("drain_vld", 32'(bus.out_valid), 32'd0);

    // Rounding behaviour, mode changed sample by sample.
    send(0, 32'h0001_8000, 1'b0, 16'h0001, "trunc_pos");
    send(0, 32'h0001_8000, 1'b1, 16'h0002, "round_pos");
    send(0, 32'hFFFF_7FFF, 1'b1, 16'hFFFF, "round_neg");
    send(0, 32'hFFFF_7FFF, 1'b0, 16'hFFFF, "trunc_neg");
    send(0, 32'h7FFF_8000, 1'b0, 16'h7FFF, "trunc_max");
    chk("trunc_no_sat", 32'(sat_count), 32'd0);
    send(0, 32'h8000_0000, 1'b1, 16'h8000, "round_min");
    chk("neg_no_sat", 32'(sat_count), 32'd0);
    send(1, 32'h0002_7FFF, 1'b1, 16'h0002, "round_below_half");

    // Saturation counting and clear.
    send(0, 32'h7FFF_8000, 1'b1, 16'h7FFF, "sat1");
    chk("sat_cnt_1", 32'(sat_count), 32'd1);
    sat_clr = 1'b1;
    send(0, 32'h7FFF_8000, 1'b1, 16'h7FFF, "sat_clr_same");
    sat_clr = 1'b0;
    chk("sat_clr_prio", 32'(sat_count), 32'd0);
    send(0, 32'h7FFF_8000, 1'b1, 16'h7FFF, "sat2a");
    send(2, 32'h7FFF_FFFF, 1'b1, 16'h7FFF, "sat2b");
    chk("sat_cnt_2", 32'(sat_count), 32'd2);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr_alone", 32'(sat_count), 32'd0);
    send(0, 32'h7FFF_8000, 1'b1, 16'h7FFF, "sat3");
    chk("sat_cnt_3", 32'(sat_count), 32'd1);

    // Backpressure: result held, no grants, then requester 2 wins.
    send(0, 32'h00AA_0000, 1'b0, 16'h00AA, "hold_setup");
    bus.out_ready   = 1'b0;
    bus.req_data[0] = 32'h0011_0000;
    bus.req_data[2] = 32'h0022_0000;
    bus.req_valid   = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_rdy", 32'(bus.req_ready), 32'd0);
      tick();
      chk("hold_vld", 32'(bus.out_valid), 32'd1);
      chk("hold_dat", 32'(bus.out_data),  32'h00AA);
      chk("hold_id",  32'(bus.out_id),    32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_rdy", 32'(bus.req_ready), 32'b0100);
    tick();
    chk("release_id",  32'(bus.out_id),    32'd2);
    chk("release_dat", 32'(bus.out_data),  32'h0022);
    chk("release_rdy2", 32'(bus.req_ready), 32'b0001);
    tick();
    chk("release2_id",  32'(bus.out_id),   32'd0);
    chk("release2_dat", 32'(bus.out_data), 32'h0011);

    // Reset while FULL and stalled: result dropped immediately.
    bus.out_ready = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    chk("pre_rst_vld", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_rdy", 32'(bus.req_ready), 32'd0);
    chk("pre_rst_sat", 32'(sat_count),     32'd1);
    rst = 1'b1;
    #1;
    chk("arst_vld", 32'(bus.out_valid), 32'd0);
    chk("arst_dat", 32'(bus.out_data),  32'd0);
    chk("arst_id",  32'(bus.out_id),    32'd0);
    chk("arst_sat", 32'(sat_count),     32'd0);
    chk("arst_rdy", 32'(bus.req_ready), 32'd0);
    tick();
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(bus.req_ready), 32'd1);
    tick();
    chk("post_rst_vld",  32'(bus.out_valid), 32'd1);
    chk("post_rst_id",   32'(bus.out_id),    32'd0);
    chk("post_rst_dat",  32'(bus.out_data),  32'h0011);
    chk("post_rst_rdy2", 32'(bus.req_ready), 32'b0010);
    bus.req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_scheduler.md
ROUND_SCHEDULER -- requirements
Module: round_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the rounding datapath (2..8).
REQ-002 Parameter IN_W, default 32, requester sample width (signed two's complement, Q16.16).
REQ-003 Parameter OUT_W, default 16, rounded output width (signed).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  N_REQ  per-requester sample valid.
REQ-007 req_data  in  N_REQ x IN_W  per-requester sample.
REQ-008 req_ready  out  N_REQ  per-requester accept strobe, one-hot or zero.
REQ-009 round_mode  in  1  0 = truncate, 1 = round-half-up with saturation.
REQ-010 out_valid  out  1  output register holds a result.
REQ-011 out_data  out  OUT_W  rounded result.
REQ-012 out_id  out  clog2(N_REQ)  index of requester that produced out_data.
REQ-013 out_ready  in  1  downstream accept.
REQ-014 sat_count  out  16  saturation event counter.
REQ-015 sat_clr  in  1  synchronous clear of sat_count.

Function
REQ-016 Transfer on requester i occurs when req_valid[i] and req_ready[i] are both 1 in the same cycle.
REQ-017 Output transfer occurs when out_valid and out_ready are both 1.
REQ-018 Output stage has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 Grant is permitted in a cycle iff state is EMPTY, or state is FULL and out_ready=1.
REQ-020 When permitted, exactly one req_ready bit is asserted: the first requester with req_valid=1 searching from (last_grant+1) mod N_REQ upward with wrap-around.
REQ-021 req_ready is combinational from req_valid, state, out_ready and pointer; req_ready shall not depend on req_data.
REQ-022 No req_valid set or grant not permitted -> req_ready all zero, pointer unchanged.
REQ-023 last_grant updates to the granted index only on a transfer.
REQ-024 Latency: a sample accepted in cycle n appears on out_data/out_id with out_valid=1 in cycle n+1.
REQ-025 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on output transfer with no input transfer; FULL->FULL on simultaneous output and input transfer (back-to-back, full throughput); FULL holds with out_data/out_id stable while out_ready=0.
REQ-026 round_mode is sampled in the transfer cycle; changes mid-stream affect only subsequent samples.
REQ-027 Truncate: out_data = req_data[IN_W-1:IN_W-OUT_W] (arithmetic shift right by IN_W-OUT_W).
REQ-028 Round: compute req_data + 2^(IN_W-OUT_W-1) at IN_W+1 bits, take upper OUT_W bits; if positive overflow occurs, out_data = 0x7FFF.
REQ-029 Negative values never saturate in round mode; truncate mode never saturates.
REQ-030 sat_count increments by 1 on each accepted sample that saturates; sticks at 0xFFFF.
REQ-031 sat_clr=1 forces sat_count to 0 next cycle; sat_clr has priority over a simultaneous increment.

Reset
REQ-032 rst asserted forces immediately: out_valid=0, out_data=0, out_id=0, sat_count=0, state EMPTY, last_grant=N_REQ-1 (requester 0 highest priority first).
REQ-033 req_ready all zero while rst=1.
REQ-034 Reset mid-operation discards the held result without an output transfer.
REQ-035 First grant is permitted in the first rising edge after rst deasserts.

Structure
REQ-036 Package fft_pkg holds IN_W/OUT_W defaults, round_mode_e enum (RND_TRUNC, RND_HALF_UP) and the rounding/saturation function.
REQ-037 Round-robin selection is a sub-module rr_arbiter (inputs: request vector, pointer, enable; outputs: one-hot grant, grant index).
REQ-038 Output register, state and sat_count live in round_scheduler.

Verification
REQ-039 Reset, req_valid=4'b1111 held, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, out_id follows one cycle later, no bubbles.
REQ-040 round_mode=0, data 0x0001_8000 -> out_data 0x0001; round_mode=1, same data -> 0x0002; data 0xFFFF_7FFF mode 1 -> 0xFFFF.
REQ-041 round_mode=1, data 0x7FFF_8000 -> out_data 0x7FFF, sat_count 0->1; repeat with sat_clr=1 same cycle -> sat_count 0.
REQ-042 out_ready=0 for 5 cycles with req_valid=4'b0101 -> out_data/out_id stable, req_ready zero; release -> requester 2 granted next.
REQ-043 rst pulsed while FULL and out_ready=0 -> out_valid drops asynchronously; after release, requester 0 granted first.
